// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
`default_nettype none

package seq_det_pkg;

  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;

  // Widest pattern the mask helper supports; PAT_W must not exceed this.
  localparam int MASK_MAX_W = 64;

  function automatic logic [MASK_MAX_W-1:0] len_mask(input int len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_cmp.sv
// Combinational match check: masked compare of {hist, in} against the pattern,
// gated by the number of valid history bits.
`default_nettype none

module seq_match_cmp
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = 8,
  parameter int LEN_W  = 4,
  parameter int FILL_W = 3
) (
  input  logic [PAT_W-2:0]  hist_i,
  input  logic              in_i,
  input  logic [PAT_W-1:0]  pattern_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [FILL_W-1:0] fill_i,
  output logic              match_o
);

  logic [MASK_MAX_W-1:0] full_mask;
  logic [PAT_W-1:0]      window;
  logic [LEN_W-1:0]      fill_ext;
  logic                  bits_eq;
  logic                  enough_bits;

  assign full_mask = len_mask(int'(len_i));
  assign window    = {hist_i, in_i};
  assign fill_ext  = LEN_W'(fill_i);
  assign bits_eq   = (((window ^ pattern_i) & full_mask[PAT_W-1:0]) == '0);

  // L=0 never matches; otherwise L-1 prior bits must be valid.
  assign enough_bits = (len_i != '0) && (fill_ext >= (len_i - LEN_W'(1)));
  assign match_o     = bits_eq && enough_bits;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy serial sequence detector with overlap control
// and a saturating match counter; reset defaults give the legacy 1101 detector.
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'b0000_1101),
  parameter int               DEF_LEN     = 4,
  parameter logic             DEF_MODE    = 1'b0,
  localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_mode,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [LEN_W-1:0]  len_q,  len_d;
  logic              mode_q, mode_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic             cmp_match;
  logic [PAT_W-1:0] shifted;

  seq_match_cmp #(
    .PAT_W  (PAT_W),
    .LEN_W  (LEN_W),
    .FILL_W (FILL_W)
  ) u_cmp (
    .hist_i    (hist_q),
    .in_i      (in),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .fill_i    (fill_q),
    .match_o   (cmp_match)
  );

  assign out       = en && !cfg_load && rst && cmp_match;
  assign shifted   = {hist_q, in};
  assign match_cnt = cnt_q;

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    mode_d = mode_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
      mode_d = cfg_mode;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      // Non-overlap discards the matched bits so the next match starts fresh.
      if (out && (mode_q == MODE_NONOVERLAP)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shifted[PAT_W-2:0];
        if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
      end
      if (out && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_d_reset: begin
        pat_q  <= DEF_PATTERN;
        len_q  <= LEN_W'(DEF_LEN);
        mode_q <= DEF_MODE;
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
      end
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default, overlap, gating, reset,
// saturation, zero-length and clamped-length scenarios.
`default_nettype none

module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_b;
  logic       en;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_mode;
  logic       out1, out2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;

  seq_detector_param u_dut (
    .clk(clk), .rst(rst), .in(in_b), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .out(out1), .match_cnt(cnt1)
  );

  seq_detector_param #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .in(in_b), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .out(out2), .match_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic b, input logic e);
    @(negedge clk);
    in_b = b; en = e; cfg_load = 1'b0;
    #1;
  endtask

  // Holds cfg_load across exactly one rising edge; the next drive drops it.
  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic m);
    @(negedge clk);
    cfg_pattern = p; cfg_len = l; cfg_mode = m;
    cfg_load = 1'b1; en = 1'b1; in_b = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    n_vec++; if (out1 !== 1'b0) begin n_err++; $display("FAIL reset_out: got %0b expected 0", out1); end
    n_vec++; if (cnt1 !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", cnt1); end
    n_vec++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL reset_cnt_sat: got %0d expected 0", cnt2); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_default;
    logic [6:0] s, e;
    s = 7'b1101101; e = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      drive(s[i], 1'b1);
      n_vec++;
      if (out1 !== e[i]) begin n_err++; $display("FAIL default_bit%0d: got %0b expected %0b", 7-i, out1, e[i]); end
    end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL default_cnt: got %0d expected 1", cnt1); end
  endtask

  task automatic test_overlap_1101;
    logic [6:0] s, e;
    s = 7'b1101101; e = 7'b0001001;
    load_cfg(8'b0000_1101, 4'd4, 1'b1);
    n_vec++; if (out1 !== 1'b0) begin n_err++; $display("FAIL cfg_priority_out: got %0b expected 0", out1); end
    for (int i = 6; i >= 0; i--) begin
      drive(s[i], 1'b1);
      n_vec++;
      if (out1 !== e[i]) begin n_err++; $display("FAIL ovl1101_bit%0d: got %0b expected %0b", 7-i, out1, e[i]); end
    end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt1 !== 16'd2) begin n_err++; $display("FAIL ovl1101_cnt: got %0d expected 2", cnt1); end
  endtask

  task automatic test_ones;
    logic [4:0] e_ovl, e_non;
    e_ovl = 5'b00111; e_non = 5'b00100;
    load_cfg(8'b0000_0111, 4'd3, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, 1'b1);
      n_vec++;
      if (out1 !== e_ovl[i]) begin n_err++; $display("FAIL ones_ovl_bit%0d: got %0b expected %0b", 5-i, out1, e_ovl[i]); end
    end
    load_cfg(8'b0000_0111, 4'd3, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, 1'b1);
      n_vec++;
      if (out1 !== e_non[i]) begin n_err++; $display("FAIL ones_non_bit%0d: got %0b expected %0b", 5-i, out1, e_non[i]); end
    end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL ones_non_cnt: got %0d expected 1", cnt1); end
  endtask

  task automatic test_en_gap;
    logic [2:0] s, g;
    s = 3'b110; g = 3'b101;
    load_cfg(8'b0000_1101, 4'd4, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      drive(s[i], 1'b1);
      n_vec++;
      if (out1 !== 1'b0) begin n_err++; $display("FAIL gap_pre_bit%0d: got %0b expected 0", 3-i, out1); end
    end
    for (int i = 2; i >= 0; i--) begin
      drive(g[i], 1'b0);
      n_vec++;
      if (out1 !== 1'b0) begin n_err++; $display("FAIL gap_idle%0d: got %0b expected 0", 3-i, out1); end
    end
    drive(1'b1, 1'b1);
    n_vec++; if (out1 !== 1'b1) begin n_err++; $display("FAIL gap_final: got %0b expected 1", out1); end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL gap_cnt: got %0d expected 1", cnt1); end
  endtask

  task automatic test_saturation;
    load_cfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1);
      n_vec++;
      if (out1 !== 1'b1 || out2 !== 1'b1) begin
        n_err++; $display("FAIL len1_bit%0d: got %0b/%0b expected 1/1", i+1, out1, out2);
      end
    end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt1 !== 16'd6) begin n_err++; $display("FAIL len1_cnt: got %0d expected 6", cnt1); end
    n_vec++; if (cnt2 !== 2'd3) begin n_err++; $display("FAIL sat_cnt: got %0d expected 3", cnt2); end
    load_cfg(8'h01, 4'd1, 1'b1);
    n_vec++; if (out1 !== 1'b0) begin n_err++; $display("FAIL load_blocks_match: got %0b expected 0", out1); end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL load_clears_cnt: got %0d expected 0", cnt2); end
  endtask

  task automatic test_len_edges;
    logic [3:0] z;
    logic [7:0] s, e;
    z = 4'b0011;
    load_cfg(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 1'b1);
      n_vec++;
      if (out1 !== 1'b0) begin n_err++; $display("FAIL len0_bit%0d: got %0b expected 0", i+1, out1); end
    end
    load_cfg(8'h00, 4'd3, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b1);
      n_vec++;
      if (out1 !== z[i]) begin n_err++; $display("FAIL zeros_bit%0d: got %0b expected %0b", 4-i, out1, z[i]); end
    end
    s = 8'hA5; e = 8'h01;
    load_cfg(8'hA5, 4'd15, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive(s[i], 1'b1);
      n_vec++;
      if (out1 !== e[i]) begin n_err++; $display("FAIL clamp_bit%0d: got %0b expected %0b", 8-i, out1, e[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] s, e;
    s = 5'b11101; e = 5'b00001;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    in_b = 1'b1; en = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_vec++; if (out1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_out: got %0b expected 0", out1); end
    n_vec++; if (cnt1 !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d expected 0", cnt1); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      drive(s[i], 1'b1);
      n_vec++;
      if (out1 !== e[i]) begin n_err++; $display("FAIL rst_fresh_bit%0d: got %0b expected %0b", 5-i, out1, e[i]); end
    end
    drive(1'b0, 1'b0);
    n_vec++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL rst_fresh_cnt: got %0d expected 1", cnt1); end
  endtask

  initial begin
    rst = 1'b0; in_b = 1'b1; en = 1'b1; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_mode = 1'b0;
    #2;
    test_reset;
    test_default;
    test_overlap_1101;
    test_ones;
    test_en_gap;
    test_saturation;
    test_len_edges;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial sequence detector. It generalises the fixed 4-bit Mealy detectors in the sequence-detector family.
- Pattern, pattern length and overlap/non-overlap mode are loaded at runtime. A saturating match counter is included.
- Sits on a 1-bit serial input stream. Flags a match combinationally (Mealy) in the same cycle as the final pattern bit.
- Reset defaults reproduce the legacy 1101 non-overlapping detector.

Parameters:
- PAT_W, 8: maximum pattern length in bits (>=2).
- CNT_W, 16: width of the match counter.
- DEF_PATTERN, 8'b0000_1101: pattern loaded at reset (LSB-aligned, PAT_W bits).
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_MODE, 0: mode loaded at reset (0 = non-overlap, 1 = overlap).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- in  input  1  serial data bit.
- en  input  1  bit-valid; `in` is consumed on a clk edge only when en=1.
- cfg_load  input  1  strobe; latches cfg_pattern, cfg_len and cfg_mode, and clears detection state.
- cfg_pattern  input  PAT_W  new pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len  input  $clog2(PAT_W+1)  new pattern length.
- cfg_mode  input  1  new mode.
- out  output  1  Mealy match flag.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0, async):
  - history and fill cleared; match_cnt=0.
  - Config registers take DEF_PATTERN, DEF_LEN and DEF_MODE.
  - out=0 while rst=0.
- State:
  - hist[PAT_W-2:0]: previous accepted bits, newest at bit 0.
  - fill: count of valid history bits, 0..PAT_W-1, saturating.
- Effective length L:
  - cfg_len is clamped to PAT_W on load.
  - L=0 or L=1 is legal. L=0 never matches. L=1 compares `in` only.
- Match (combinational):
  - Condition: en=1, cfg_load=0, rst=1, fill >= L-1, L>=1, and the low L bits of {hist, in} equal the low L bits of the pattern.
  - When the condition holds, out=1 in that same cycle. Otherwise out=0.
- Rising edge with en=1, cfg_load=0:
  - No match, or match in overlap mode: hist shifts left with `in` entering bit 0; fill increments, saturating at PAT_W-1.
  - Match in non-overlap mode: hist cleared and fill=0. The matched bits are not reused.
- Rising edge with en=0: hist, fill and match_cnt hold; out=0.
- cfg_load=1:
  - Has priority over en; the bit on `in` that cycle is discarded and out=0.
  - Next edge: config registers load, hist/fill clear, match_cnt clears.
- match_cnt: increments on every edge where out=1; holds at 2^CNT_W-1.
- Reset asserted mid-pattern: partial history is lost. The first match after release requires a full L bits.
- A pattern longer than the number of bits seen never matches; fill gates this.
- Behaviour is identical regardless of pattern content, including all-0 and all-1 patterns.

Decomposition:
- Package seq_det_pkg holds:
  - MODE_NONOVERLAP=1'b0 and MODE_OVERLAP=1'b1;
  - a function computing the L-bit compare mask from the length.
- One combinational sub-module, seq_match_cmp: masked equality of {hist, in} against the pattern, plus the fill check.
- The top level owns all registers: config, history, fill and counter.

Test Plan:
- Defaults after reset, en=1, stream 1,1,0,1,1,0,1 -> out=1 on bit 4 only; match_cnt=1 (non-overlap 1101).
- cfg_load with pattern 4'b1101, len=4, mode=1, then the same stream -> out=1 on bits 4 and 7; match_cnt=2.
- Pattern 3'b111, len=3, mode=1, stream 1,1,1,1,1 -> out=1 on bits 3, 4 and 5. Same stream with mode=0 -> out=1 on bit 3 only.
- Stream 1,1,0 with en deasserted for 3 cycles, then 1 -> out=1 on the final bit. No out pulse while en=0; history is preserved across the gap.
- Stream 1,1,0, then rst low mid-cycle, release, then 1 -> out=0 (history cleared). Fresh 1,1,0,1 -> match.
- CNT_W=2, overlap pattern len=1 '1', stream of 6 ones -> match_cnt saturates at 3. cfg_len=0 -> out never asserts.
